// File: rtl/lfsr_pkg.sv
// Shared LFSR constants and the maximal-length XNOR tap table (XAPP052).
package lfsr_pkg;

    localparam int LFSR_MIN_BITS = 3;
    localparam int LFSR_MAX_BITS = 32;

    function automatic logic [LFSR_MAX_BITS-1:0] tap_bit(input int pos);
        return {{(LFSR_MAX_BITS-1){1'b0}}, 1'b1} << (pos - 1);
    endfunction

    // Positions are 1-indexed; bit (p-1) of the mask marks tap p.
    function automatic logic [LFSR_MAX_BITS-1:0] lfsr_taps(input int width);
        logic [LFSR_MAX_BITS-1:0] mask;
        mask = '0;
        case (width)
            3:  mask = tap_bit(3)  | tap_bit(2);
            4:  mask = tap_bit(4)  | tap_bit(3);
            5:  mask = tap_bit(5)  | tap_bit(3);
            6:  mask = tap_bit(6)  | tap_bit(5);
            7:  mask = tap_bit(7)  | tap_bit(6);
            8:  mask = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
            9:  mask = tap_bit(9)  | tap_bit(5);
            10: mask = tap_bit(10) | tap_bit(7);
            11: mask = tap_bit(11) | tap_bit(9);
            12: mask = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            13: mask = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
            14: mask = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
            15: mask = tap_bit(15) | tap_bit(14);
            16: mask = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17: mask = tap_bit(17) | tap_bit(14);
            18: mask = tap_bit(18) | tap_bit(11);
            19: mask = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            20: mask = tap_bit(20) | tap_bit(17);
            21: mask = tap_bit(21) | tap_bit(19);
            22: mask = tap_bit(22) | tap_bit(21);
            23: mask = tap_bit(23) | tap_bit(18);
            24: mask = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25: mask = tap_bit(25) | tap_bit(22);
            26: mask = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            27: mask = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
            28: mask = tap_bit(28) | tap_bit(25);
            29: mask = tap_bit(29) | tap_bit(27);
            30: mask = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            31: mask = tap_bit(31) | tap_bit(28);
            32: mask = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Combinational XNOR feedback for a maximal-length LFSR of width NUM_BITS.
module lfsr_feedback
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic [NUM_BITS-1:0] state,
    output logic                fb
);

    localparam logic [LFSR_MAX_BITS-1:0] TAP_MASK = lfsr_taps(NUM_BITS);

    // XNOR keeps all-zeros legal and makes all-ones the lock-up state.
    assign fb = ~^(state & TAP_MASK[NUM_BITS-1:0]);

endmodule

// File: rtl/lfsr.sv
// XNOR LFSR with seed load and enable; LFSR_done is built only when LFSR_DONE_EN is defined.
module lfsr
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                seed_DV,
    input  logic [NUM_BITS-1:0] seed,
`ifdef LFSR_DONE_EN
    output logic                LFSR_done,
`endif
    output logic [NUM_BITS-1:0] LFSR_data
);

    logic [NUM_BITS-1:0] state;
    logic                fb;

    generate
        if (NUM_BITS < LFSR_MIN_BITS || NUM_BITS > LFSR_MAX_BITS) begin : g_bad_width
            $error("lfsr: NUM_BITS=%0d outside legal range %0d..%0d",
                   NUM_BITS, LFSR_MIN_BITS, LFSR_MAX_BITS);
        end
    endgenerate

    lfsr_feedback #(
        .NUM_BITS(NUM_BITS)
    ) u_feedback (
        .state(state),
        .fb   (fb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= '0;
        end else if (en) begin
            if (seed_DV) begin
                state <= seed;
            end else begin
                state <= {state[NUM_BITS-2:0], fb};
            end
        end
    end

    assign LFSR_data = state;

`ifdef LFSR_DONE_EN
    // Compares against the live seed input, independent of en.
    assign LFSR_done = (state == seed);
`endif

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr (NUM_BITS=8) against an arithmetic reference model.
module tb_lfsr;

    localparam int W = 8;
    localparam int TAPS [4] = '{8, 6, 5, 4};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         seed_DV;
    logic [W-1:0] seed;
    logic [W-1:0] data;
`ifdef LFSR_DONE_EN
    logic         done;
    int           done_pulses;
`endif

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] model;
    logic [W-1:0] snap;
    bit           seen [256];
    int           seen_count;

    lfsr #(
        .NUM_BITS(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .seed_DV  (seed_DV),
        .seed     (seed),
`ifdef LFSR_DONE_EN
        .LFSR_done(done),
`endif
        .LFSR_data(data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Next value from the rule: shift left one place, drop the top bit, append XNOR of taps.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] s);
        int ones = 0;
        int v = int'(s);
        foreach (TAPS[i]) ones += (v >> (TAPS[i] - 1)) % 2;
        return W'(((v * 2) % 256) + ((ones % 2 == 0) ? 1 : 0));
    endfunction

    task automatic tick();
        if (!rst_n)       model = '0;
        else if (!en)     model = model;
        else if (seed_DV) model = seed;
        else              model = ref_next(model);
        @(posedge clk);
        #1;
    endtask

    task automatic tick_check(input string tag);
        tick();
        check_val(tag, 32'(data), 32'(model));
`ifdef LFSR_DONE_EN
        check_val({tag, "_done"}, 32'(done), 32'(model == seed));
`endif
    endtask

    initial begin
        logic [W-1:0] exp_seq [4];
        model = '0;

        // Reset wins over en and seed_DV.
        rst_n = 1'b0; en = 1'b1; seed_DV = 1'b1; seed = 8'hAA;
        tick();
        check_val("reset_over_load", 32'(data), 32'h00);

        // First shifts out of reset.
        rst_n = 1'b1; seed_DV = 1'b0;
        exp_seq = '{8'h01, 8'h03, 8'h07, 8'h0F};
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("post_reset_seq", 32'(data), 32'(exp_seq[i]));
        end

        // Load F0 mid-sequence, then known successors.
        seed = 8'hF0; seed_DV = 1'b1;
        tick_check("load_f0");
        check_val("load_f0_const", 32'(data), 32'hF0);
        seed_DV = 1'b0;
        exp_seq = '{8'hE0, 8'hC1, 8'h82, 8'h04};
        for (int i = 0; i < 4; i++) begin
            tick_check("f0_model");
            check_val("f0_seq", 32'(data), 32'(exp_seq[i]));
        end

        // Hold with en low while seed_DV toggles and seed changes.
        snap = data;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seed_DV = 1'(i % 2);
            seed = 8'($urandom);
            tick_check("hold_model");
            check_val("hold", 32'(data), 32'(snap));
        end
        en = 1'b1; seed_DV = 1'b0;

        // Seed changes without seed_DV do not disturb shifting.
        for (int i = 0; i < 4; i++) begin
            seed = 8'($urandom);
            tick_check("seed_ignored");
        end

        // Held seed_DV reloads every cycle.
        seed = 8'h5A; seed_DV = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_check("held_load");
            check_val("held_load_const", 32'(data), 32'h5A);
        end
        seed_DV = 1'b0;
        tick_check("after_held_load");

        // Mid-sequence reset leaves no residue.
        rst_n = 1'b0;
        tick();
        check_val("mid_reset", 32'(data), 32'h00);
        rst_n = 1'b1;
        tick();
        check_val("mid_reset_first_shift", 32'(data), 32'h01);

        // Full period from seed 01.
        seed = 8'h01; seed_DV = 1'b1;
`ifdef LFSR_DONE_EN
        done_pulses = 0;
`endif
        tick_check("period_load");
`ifdef LFSR_DONE_EN
        done_pulses += int'(done);
`endif
        seed_DV = 1'b0;
        foreach (seen[i]) seen[i] = 1'b0;
        seen_count = 0;
        for (int i = 0; i < 255; i++) begin
            tick_check("period_model");
`ifdef LFSR_DONE_EN
            done_pulses += int'(done);
`endif
            if (seen[data]) check_val("period_unique", 32'(data), 32'hFFFF_FFFF);
            else seen_count++;
            seen[data] = 1'b1;
        end
        check_val("period_distinct", 32'(seen_count), 32'd255);
        check_val("period_no_ff", 32'(seen[8'hFF]), 32'd0);
        check_val("period_return", 32'(data), 32'h01);
`ifdef LFSR_DONE_EN
        check_val("period_done_pulses", 32'(done_pulses), 32'd2);
`endif

        // All-ones lock-up.
        seed = 8'hFF; seed_DV = 1'b1;
        tick_check("lock_load");
        seed_DV = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_check("lock_model");
            check_val("lock_ff", 32'(data), 32'hFF);
        end

        // Randomized control against the model.
        for (int i = 0; i < 400; i++) begin
            rst_n   = ($urandom_range(0, 24) != 0);
            en      = ($urandom_range(0, 3) != 0);
            seed_DV = ($urandom_range(0, 7) == 0);
            seed    = 8'($urandom);
            tick_check("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr.md
LFSR -- requirements
Module: lfsr

Interface
REQ-001 Parameter NUM_BITS, default 8, register width; legal range 3..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  enable; when low, state holds and seed_DV is ignored.
REQ-005 seed_DV  input  1  seed-valid strobe; loads seed when en=1.
REQ-006 seed  input  NUM_BITS  seed/master-challenge value.
REQ-007 LFSR_data  output  NUM_BITS  current LFSR state, driven directly from the state register.
REQ-008 LFSR_done  output  1  sequence-wrap flag; present only when LFSR_DONE_EN is defined.

Function
REQ-009 Per rising edge, priority SHALL be: rst_n=0 > en=0 (hold) > seed_DV=1 (load seed) > shift.
REQ-010 Shift SHALL be state <= {state[NUM_BITS-2:0], fb}, with fb the XNOR of the tap bits for NUM_BITS.
REQ-011 Taps SHALL follow the maximal-length XNOR table (Xilinx XAPP052), 1-indexed bit positions, e.g. 3:{3,2}, 4:{4,3}, 5:{5,3}, 8:{8,6,5,4}, 16:{16,15,13,4}, 32:{32,22,2,1}.
REQ-012 The sequence period from any non-all-ones state SHALL be 2^NUM_BITS-1.
REQ-013 All-ones is the lock-up state: once entered, by seed or otherwise, the state SHALL remain all-ones.
REQ-014 A load SHALL take effect in one cycle: LFSR_data equals seed on the edge after seed_DV=1 and en=1 are sampled.
REQ-015 seed_DV asserted mid-sequence SHALL reload immediately and discard the current state.
REQ-016 seed_DV held high for multiple cycles SHALL reload every cycle, so the output stays at seed.
REQ-017 seed changes while seed_DV=0 SHALL NOT affect the state.
REQ-018 Widths SHALL be exact; no carries or padding, and bit NUM_BITS-1 is discarded on each shift.

Reset
REQ-019 rst_n=0 at a rising edge SHALL clear the state to all-zeros, overriding en and seed_DV.
REQ-020 After reset with en=1 and seed_DV=0, the first shift SHALL produce 0...01.
REQ-021 Reset asserted mid-sequence SHALL take effect on the next edge with no residual state.

Configuration
REQ-022 Macro LFSR_DONE_EN defined: port LFSR_done SHALL exist and be high combinationally whenever LFSR_data == seed, regardless of en; this includes the cycle right after a load.
REQ-023 Macro LFSR_DONE_EN undefined: port LFSR_done and its comparator SHALL be absent, with no other behavioural change.

Structure
REQ-024 Package lfsr_pkg SHALL hold constants LFSR_MIN_BITS=3 and LFSR_MAX_BITS=32, plus the tap-table function returning the tap mask for a given width.
REQ-025 Sub-module lfsr_feedback (combinational: state in, fb out, NUM_BITS parameter) SHALL compute the XNOR feedback.
REQ-026 The top level SHALL hold the state register and the load/hold/shift multiplexing.
REQ-027 An out-of-range NUM_BITS SHALL cause an elaboration-time error.

Verification
REQ-028 NUM_BITS=8, rst_n=1, en=1, seed_DV=1 for one cycle with seed=8'hF0 -> LFSR_data is F0 then, on successive cycles, E0, C1, 82, 04.
REQ-029 rst_n=0 for one cycle -> LFSR_data=00; then en=1, seed_DV=0 -> 01, 03, 07 on successive cycles.
REQ-030 en=0 for 5 cycles mid-sequence, with seed_DV toggling -> LFSR_data unchanged.
REQ-031 Load seed 8'h01 and run 255 shifts -> all 255 non-FF values appear exactly once and the state returns to 01; with LFSR_DONE_EN defined, LFSR_done pulses on the load cycle and again at shift 255.
REQ-032 Load seed 8'hFF -> LFSR_data stays FF for 10 cycles.
REQ-033 Assert rst_n=0 and seed_DV=1 together -> LFSR_data=00.
